// File: rtl/dragon_pkg.sv
// Shared types and constants for the dragon movement engine.
package dragon_pkg;

    localparam int GRID_SIZE = 16;

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
    } pos_t;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    typedef enum logic [1:0] {
        CHASE,
        ARRIVED,
        STUN
    } state_t;

    function automatic logic [4:0] abs5(input logic signed [4:0] v);
        return v[4] ? 5'(-v) : 5'(v);
    endfunction

endpackage

// File: rtl/dragon_step_calc.sv
// Combinational next-cell calculator for the dragon.
// DRAGON_DIAGONAL_EN allows a combined X+Y step when both deltas are nonzero.
module dragon_step_calc
    import dragon_pkg::*;
(
    input  pos_t       cur_pos,
    input  pos_t       tgt_pos,
    output pos_t       next_pos,
    output logic [1:0] next_dir,
    output logic       at_target
);

    logic signed [4:0] dx;
    logic signed [4:0] dy;
    logic [4:0]        adx;
    logic [4:0]        ady;
    logic              step_x;
    logic              step_y;

    assign dx  = 5'({1'b0, tgt_pos.x}) - 5'({1'b0, cur_pos.x});
    assign dy  = 5'({1'b0, tgt_pos.y}) - 5'({1'b0, cur_pos.y});
    assign adx = abs5(dx);
    assign ady = abs5(dy);
    assign at_target = (cur_pos == tgt_pos);

`ifdef DRAGON_DIAGONAL_EN
    assign step_x = (dx != 5'sd0);
    assign step_y = (dy != 5'sd0);
`else
    // Ties favour the X axis.
    assign step_x = (dx != 5'sd0) && (adx >= ady);
    assign step_y = (dy != 5'sd0) && (adx < ady);
`endif

    always_comb begin
        next_pos   = cur_pos;
        next_dir   = DIR_RIGHT;
        if (step_x) begin
            next_pos.x = cur_pos.x + (dx[4] ? 4'hF : 4'h1);
        end
        if (step_y) begin
            next_pos.y = cur_pos.y + (dy[4] ? 4'hF : 4'h1);
        end
        unique case (1'b1)
            step_x:  next_dir = dx[4] ? DIR_LEFT : DIR_RIGHT;
            step_y:  next_dir = dy[4] ? DIR_UP : DIR_DOWN;
            default: next_dir = DIR_RIGHT;
        endcase
    end

endmodule

// File: rtl/dragon_pursuit.sv
// Dragon movement engine: paced grid walk toward a target with hurt stun.
// Diagonal stepping is selected by DRAGON_DIAGONAL_EN in dragon_step_calc.
module dragon_pursuit
    import dragon_pkg::*;
#(
    parameter int         MOVE_PERIOD = 4,
    parameter int         STUN_FRAMES = 8,
    parameter logic [7:0] START_POS   = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       trigger,
    input  pos_t       target_pos,
    input  logic       dragon_hurt,
    output pos_t       dragon_pos,
    output logic [1:0] dragon_direction,
    output logic       target_reached,
    output logic       moving,
    output logic       stunned
);

    localparam logic [3:0] LAST_MOVE = 4'(MOVE_PERIOD - 1);
    localparam logic [7:0] STUN_LOAD = 8'(STUN_FRAMES);

    state_t     state;
    logic [3:0] move_cnt;
    logic [7:0] stun_cnt;
    pos_t       next_pos;
    logic [1:0] next_dir;
    logic       at_target;

    dragon_step_calc u_step (
        .cur_pos  (dragon_pos),
        .tgt_pos  (target_pos),
        .next_pos (next_pos),
        .next_dir (next_dir),
        .at_target(at_target)
    );

    assign moving  = (state == CHASE) && (dragon_pos != target_pos);
    assign stunned = (state == STUN);

    // Hurt outranks both stepping and arrival in every state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= CHASE;
            dragon_pos       <= pos_t'(START_POS);
            dragon_direction <= DIR_RIGHT;
            target_reached   <= 1'b0;
            move_cnt         <= 4'd0;
            stun_cnt         <= 8'd0;
        end else begin
            target_reached <= 1'b0;
            unique case (state)
                CHASE: begin
                    if (dragon_hurt) begin
                        state    <= STUN;
                        stun_cnt <= STUN_LOAD;
                    end else if (trigger) begin
                        if (move_cnt == LAST_MOVE) begin
                            move_cnt <= 4'd0;
                            if (at_target) begin
                                state          <= ARRIVED;
                                target_reached <= 1'b1;
                            end else begin
                                dragon_pos       <= next_pos;
                                dragon_direction <= next_dir;
                            end
                        end else begin
                            move_cnt <= move_cnt + 4'd1;
                        end
                    end
                end
                ARRIVED: begin
                    if (dragon_hurt) begin
                        state    <= STUN;
                        stun_cnt <= STUN_LOAD;
                    end else if (trigger && (target_pos != dragon_pos)) begin
                        state    <= CHASE;
                        move_cnt <= 4'd0;
                    end
                end
                STUN: begin
                    if (dragon_hurt) begin
                        stun_cnt <= STUN_LOAD;
                    end else if (trigger) begin
                        if (stun_cnt == 8'd1) begin
                            state    <= CHASE;
                            move_cnt <= 4'd0;
                            stun_cnt <= 8'd0;
                        end else begin
                            stun_cnt <= stun_cnt - 8'd1;
                        end
                    end
                end
                default: state <= CHASE;
            endcase
        end
    end

endmodule

// File: tb/tb_dragon_pursuit.sv
// Directed scoreboard bench for dragon_pursuit.
module tb_dragon_pursuit;

    typedef struct {
        logic [7:0] pos;
        logic [1:0] dir;
        logic       reached;
        int         trig;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       trigger;
    logic [7:0] target_pos;
    logic       dragon_hurt;
    logic [7:0] dragon_pos;
    logic [1:0] dragon_direction;
    logic       target_reached;
    logic       moving;
    logic       stunned;

    int   checks = 0;
    int   failures = 0;
    int   trig_n = 0;
    bit   mon_en = 1'b0;
    logic [7:0] prev_pos = 8'h00;
    ev_t  exp_q[$];

    dragon_pursuit #(
        .MOVE_PERIOD(4),
        .STUN_FRAMES(8),
        .START_POS  (8'h00)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .trigger         (trigger),
        .target_pos      (target_pos),
        .dragon_hurt     (dragon_hurt),
        .dragon_pos      (dragon_pos),
        .dragon_direction(dragon_direction),
        .target_reached  (target_reached),
        .moving          (moving),
        .stunned         (stunned)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [7:0] p, input logic [1:0] d,
                        input logic r, input int t);
        ev_t e;
        e.pos = p;
        e.dir = d;
        e.reached = r;
        e.trig = t;
        exp_q.push_back(e);
    endtask

    task automatic tick(input logic hurt = 1'b0);
        @(negedge clk);
        trigger = 1'b1;
        dragon_hurt = hurt;
        trig_n++;
        @(negedge clk);
        trigger = 1'b0;
        dragon_hurt = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic hurt_pulse();
        @(negedge clk);
        dragon_hurt = 1'b1;
        @(negedge clk);
        dragon_hurt = 1'b0;
    endtask

    // Any position change or reached pulse must match the scoreboard head.
    always @(negedge clk) begin
        if (mon_en && (dragon_pos !== prev_pos || target_reached === 1'b1)) begin
            check("event_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                ev_t e;
                e = exp_q.pop_front();
                check("ev_pos", 32'(dragon_pos), 32'(e.pos));
                check("ev_dir", 32'(dragon_direction), 32'(e.dir));
                check("ev_reached", 32'(target_reached), 32'(e.reached));
                check("ev_trigger", 32'(trig_n), 32'(e.trig));
            end
        end
        prev_pos = dragon_pos;
    end

    initial begin
        int b;
        reset = 1'b1;
        trigger = 1'b0;
        dragon_hurt = 1'b0;
        target_pos = 8'h30;
        repeat (3) @(negedge clk);
        check("rst_pos", 32'(dragon_pos), 32'h00);
        check("rst_dir", 32'(dragon_direction), 32'h1);
        check("rst_reached", 32'(target_reached), 32'h0);
        check("rst_stunned", 32'(stunned), 32'h0);
        check("rst_moving", 32'(moving), 32'h1);
        reset = 1'b0;
        mon_en = 1'b1;

        // Straight walk along X, then arrival pulse.
        b = trig_n;
        push(8'h10, 2'b01, 1'b0, b + 4);
        push(8'h20, 2'b01, 1'b0, b + 8);
        push(8'h30, 2'b01, 1'b0, b + 12);
        push(8'h30, 2'b01, 1'b1, b + 16);
        repeat (20) tick();
        check("arrived_moving", 32'(moving), 32'h0);

        // Re-target from ARRIVED: walk back left.
        target_pos = 8'h00;
        b = trig_n;
        push(8'h20, 2'b11, 1'b0, b + 5);
        push(8'h10, 2'b11, 1'b0, b + 9);
        push(8'h00, 2'b11, 1'b0, b + 13);
        push(8'h00, 2'b11, 1'b1, b + 17);
        tick();
        check("retarget_moving", 32'(moving), 32'h1);
        repeat (19) tick();

        // Tie handling toward 8'h22.
        target_pos = 8'h22;
        b = trig_n;
`ifdef DRAGON_DIAGONAL_EN
        push(8'h11, 2'b01, 1'b0, b + 5);
        push(8'h22, 2'b01, 1'b0, b + 9);
        push(8'h22, 2'b01, 1'b1, b + 13);
`else
        push(8'h10, 2'b01, 1'b0, b + 5);
        push(8'h11, 2'b10, 1'b0, b + 9);
        push(8'h21, 2'b01, 1'b0, b + 13);
        push(8'h22, 2'b10, 1'b0, b + 17);
        push(8'h22, 2'b10, 1'b1, b + 21);
`endif
        repeat (23) tick();

        // Hurt on the second step's trigger, then an extended stun.
        target_pos = 8'h62;
        b = trig_n;
        push(8'h32, 2'b01, 1'b0, b + 5);
        repeat (8) tick();
        tick(1'b1);
        check("stun1_enter", 32'(stunned), 32'h1);
        check("stun1_pos", 32'(dragon_pos), 32'h32);
        repeat (7) tick();
        check("stun1_hold", 32'(stunned), 32'h1);
        check("stun1_moving", 32'(moving), 32'h0);
        tick();
        check("stun1_exit", 32'(stunned), 32'h0);
        push(8'h42, 2'b01, 1'b0, b + 21);
        repeat (5) tick();
        hurt_pulse();
        check("stun2_enter", 32'(stunned), 32'h1);
        repeat (4) tick();
        tick(1'b1);
        repeat (7) tick();
        check("stun2_hold", 32'(stunned), 32'h1);
        tick();
        check("stun2_exit", 32'(stunned), 32'h0);
        check("stun2_pos", 32'(dragon_pos), 32'h42);
        push(8'h52, 2'b01, 1'b0, b + 39);
        push(8'h62, 2'b01, 1'b0, b + 43);
        push(8'h62, 2'b01, 1'b1, b + 47);
        repeat (14) tick();

        // Asynchronous reset in the middle of a stun.
        hurt_pulse();
        repeat (3) tick();
        check("pre_rst_stunned", 32'(stunned), 32'h1);
        push(8'h00, 2'b01, 1'b0, trig_n);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_pos", 32'(dragon_pos), 32'h00);
        check("arst_stunned", 32'(stunned), 32'h0);
        check("arst_reached", 32'(target_reached), 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        target_pos = 8'h10;
        reset = 1'b0;
        b = trig_n;
        push(8'h10, 2'b01, 1'b0, b + 4);
        push(8'h10, 2'b01, 1'b1, b + 8);
        repeat (10) tick();

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("final_moving", 32'(moving), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
